// File: rtl/smg_scan_driver_if.sv
// Display-side bundle of the scan driver: frame data in, segment/digit pins out.
interface smg_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] Data_In;
    logic [DIGITS-1:0]   DP_In;
    logic [DIGITS-1:0]   Blink_In;
    logic                LZB_En;
    logic                Load;
    logic [7:0]          SMG_Data;
    logic [DIGITS-1:0]   Scan_Sig;
    logic                Frame_Start;

    modport master (
        output Data_In, DP_In, Blink_In, LZB_En, Load,
        input  SMG_Data, Scan_Sig, Frame_Start
    );

    modport slave (
        input  Data_In, DP_In, Blink_In, LZB_En, Load,
        output SMG_Data, Scan_Sig, Frame_Start
    );
endinterface

// File: rtl/smg_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with hex glyphs,
// per-digit DP/blink, leading-zero blanking, ghosting guard and frame-synced updates.
module smg_scan_driver #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int GUARD     = 16,
    parameter int BLINK_DIV = 25
) (
    input logic              CLK,
    input logic              RSTn,
    smg_scan_driver_if.slave bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_DIV - 1);

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [FW-1:0] frm_cnt;
    logic          blink_ph;
    logic          boundary;

    logic [DIGITS-1:0][3:0] pend_nib, shad_nib;
    logic [DIGITS-1:0]      pend_dp, pend_blink, shad_dp, shad_blink;
    logic                   pend_valid;

    logic [DIGITS-1:0] lz_blank;
    logic              lz_run;
    logic [7:0]        seg_nxt, seg_q;
    logic [DIGITS-1:0] scan_nxt, scan_q;
    logic              fs_q;

    function automatic logic [7:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 8'hC0;
            4'h1: glyph = 8'hF9;
            4'h2: glyph = 8'hA4;
            4'h3: glyph = 8'hB0;
            4'h4: glyph = 8'h99;
            4'h5: glyph = 8'h92;
            4'h6: glyph = 8'h82;
            4'h7: glyph = 8'hF8;
            4'h8: glyph = 8'h80;
            4'h9: glyph = 8'h90;
            4'hA: glyph = 8'h88;
            4'hB: glyph = 8'h83;
            4'hC: glyph = 8'hC6;
            4'hD: glyph = 8'hA1;
            4'hE: glyph = 8'h86;
            default: glyph = 8'h8E;
        endcase
    endfunction

    assign boundary = (idx == IDX_LAST) && (cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            frm_cnt  <= '0;
            blink_ph <= 1'b0;
        end else if (boundary) begin
            if (frm_cnt == FRM_LAST) begin
                frm_cnt  <= '0;
                blink_ph <= ~blink_ph;
            end else begin
                frm_cnt <= frm_cnt + 1'b1;
            end
        end
    end

    // A Load landing on the boundary cycle bypasses pending straight into shadow.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pend_nib   <= '0;
            pend_dp    <= '0;
            pend_blink <= '0;
            pend_valid <= 1'b0;
            shad_nib   <= '0;
            shad_dp    <= '0;
            shad_blink <= '0;
        end else begin
            if (bus.Load) begin
                pend_nib   <= bus.Data_In;
                pend_dp    <= bus.DP_In;
                pend_blink <= bus.Blink_In;
            end
            if (boundary)
                pend_valid <= 1'b0;
            else if (bus.Load)
                pend_valid <= 1'b1;
            if (boundary && (pend_valid || bus.Load)) begin
                shad_nib   <= bus.Load ? bus.Data_In  : pend_nib;
                shad_dp    <= bus.Load ? bus.DP_In    : pend_dp;
                shad_blink <= bus.Load ? bus.Blink_In : pend_blink;
            end
        end
    end

    always_comb begin
        lz_blank = '0;
        lz_run   = 1'b1;
        for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
            lz_run      = lz_run && (shad_nib[k] == 4'h0);
            lz_blank[k] = lz_run;
        end
    end

    always_comb begin
        seg_nxt  = 8'hFF;
        scan_nxt = '1;
        if (cnt >= GUARD_C) begin
            scan_nxt = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx);
            if (!(shad_blink[idx] && blink_ph) && !(bus.LZB_En && lz_blank[idx]))
                seg_nxt = glyph(shad_nib[idx]) & {~shad_dp[idx], 7'h7F};
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            seg_q  <= 8'hFF;
            scan_q <= '1;
            fs_q   <= 1'b0;
        end else begin
            seg_q  <= seg_nxt;
            scan_q <= scan_nxt;
            fs_q   <= boundary;
        end
    end

    assign bus.SMG_Data    = seg_q;
    assign bus.Scan_Sig    = scan_q;
    assign bus.Frame_Start = fs_q;
endmodule
